i2c_config_seq: RTL and testbench
=================================

I2C_CONFIG_SEQ -- requirements
Module: i2c_config_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250, clk cycles per SCL quarter-period (100 MHz clk -> 100 kHz SCL); legal range 2..1023.
REQ-002 SHALL have parameter NUM_REGS, default 9, number of config entries sent, indices 0..NUM_REGS-1; legal range 1..16.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle request to run the full configuration sequence; ignored while busy=1.
REQ-006 sda_in  in  1  sampled SDA line, used for ACK detection.
REQ-007 shift_reg_out  in  1  current MSB of the downstream byte shift register.
REQ-008 scl  out  1  SCL level; 1 = released/high.
REQ-009 sda_oe  out  1  open-drain SDA pull-down enable; 1 = drive low, 0 = release.
REQ-010 fsm_enable  out  1  permits the downstream shift register to shift.
REQ-011 middle_low_cycle_pulse  out  1  one-cycle strobe at the midpoint of each SCL low phase.
REQ-012 reg_num  out  4  config entry index presented to the data stage.
REQ-013 read  out  1  R/W bit of the device-address byte; constant 0 (write).
REQ-014 use_mem_data  out  1  0 = load device address byte, 1 = load memory byte.
REQ-015 byte_select  out  1  1 = register-address byte, 0 = register-data byte.
REQ-016 load  out  1  one-cycle strobe loading the downstream shift register.
REQ-017 busy, done, ack_error  out  1 each  sequence active / sequence finished / NACK seen.

Function
REQ-018 SHALL divide time into quarters of CLK_DIV cycles; each SCL bit period = quarters Q0..Q3; scl=0 in Q0-Q1, scl=1 in Q2-Q3.
REQ-019 middle_low_cycle_pulse SHALL be 1 for exactly the last clk of Q0 of every bit period in states BIT and ACK, 0 otherwise.
REQ-020 States SHALL be IDLE, START, BIT, ACK, STOP, GAP, DONE.
REQ-021 IDLE: scl=1, sda_oe=0, busy=0; start -> START, reg_num=0, byte counter=0, ack_error=0, done=0.
REQ-022 START (one bit period): sda_oe=0 Q0-Q1, sda_oe=1 from Q2 with scl=1 (start condition); scl=0 from its end -> BIT, bit counter=7.
REQ-023 Byte order per entry SHALL be: device address (use_mem_data=0), register address (use_mem_data=1, byte_select=1), register data (use_mem_data=1, byte_select=0); use_mem_data/byte_select stable for the whole byte including its ACK.
REQ-024 load SHALL pulse coincident with middle_low_cycle_pulse of bit 7 of each byte; fsm_enable SHALL be 1 during bits 6..0 of BIT and 0 elsewhere (7 shifts per byte).
REQ-025 In BIT, sda_oe SHALL equal ~shift_reg_out, registered one clk after middle_low_cycle_pulse and held to next bit's midpoint.
REQ-026 After bit 0 -> ACK: sda_oe=0 from the ACK midpoint; sda_in sampled on last clk of Q2.
REQ-027 ACK with sda_in=0: next byte -> BIT; after third byte -> STOP.
REQ-028 ACK with sda_in=1: ack_error set (sticky until next accepted start), -> STOP, then DONE, skipping remaining entries.
REQ-029 STOP (one bit period): sda_oe=1 Q0-Q1, scl=1 from Q2, sda_oe=0 from Q3 (stop condition).
REQ-030 STOP -> GAP (one bit period, scl=1, sda_oe=0); reg_num increments at GAP entry; reg_num==NUM_REGS-1 at STOP -> DONE instead, reg_num held.
REQ-031 reg_num SHALL be stable at least 2 clk before any load with use_mem_data=1 (covers the one-cycle memory read latency downstream).
REQ-032 DONE: busy=0, done=1 held until next accepted start; -> IDLE same cycle (IDLE preserves done).
REQ-033 start during busy SHALL have no effect; start and last-GAP cycle coincident SHALL be ignored.

Reset
REQ-034 rst_n=0 SHALL immediately force: state IDLE, scl=1, sda_oe=0, fsm_enable=0, middle_low_cycle_pulse=0, load=0, reg_num=0, read=0, use_mem_data=0, byte_select=0, busy=0, done=0, ack_error=0, counters 0.
REQ-035 Reset mid-transaction SHALL release the bus without emitting STOP; next start begins at reg_num=0.

Verification (CLK_DIV=4, NUM_REGS=2, slave always ACKs unless stated)
REQ-036 start pulse -> START, 27 bit periods, STOP, GAP per entry; done rises 2*30*16-16=944 clk after start (second entry has no GAP); decoded bytes match memory contents.
REQ-037 Per byte -> exactly 1 load, 7 fsm_enable&middle_low_cycle_pulse events; load coincident with a middle_low_cycle_pulse.
REQ-038 NACK on register-address byte of entry 0 -> ack_error=1, STOP emitted, done=1, reg_num stays 0, no further loads.
REQ-039 rst_n low during BIT of entry 1 -> scl=1, sda_oe=0, reg_num=0 same cycle, no STOP; new start restarts at entry 0.
REQ-040 start pulses during busy and on done cycle -> no restart, no counter change; SDA never changes while scl=1 except at START/STOP.

Source files
------------

// File: rtl/i2c_config_seq.sv
// rtl/i2c_config_seq.sv - I2C write sequencer streaming NUM_REGS config entries (dev addr, reg addr, reg data)
module i2c_config_seq #(
    parameter int CLK_DIV  = 250,
    parameter int NUM_REGS = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sda_in,
    input  logic       shift_reg_out,
    output logic       scl,
    output logic       sda_oe,
    output logic       fsm_enable,
    output logic       middle_low_cycle_pulse,
    output logic [3:0] reg_num,
    output logic       read,
    output logic       use_mem_data,
    output logic       byte_select,
    output logic       load,
    output logic       busy,
    output logic       done,
    output logic       ack_error
);

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, GAP, DONE} state_t;

    state_t     state;
    logic [9:0] qcnt;
    logic [1:0] quarter;
    logic [2:0] bit_cnt;
    logic [1:0] byte_cnt;
    logic       mlp_d;
    logic       nack;

    logic       q_end;
    logic       bit_end;
    logic       pre_mid;
    logic [1:0] nq;
    logic       timed;

    // Timing decode; outputs are registered, so they are computed from the position one cycle ahead
    always_comb begin
        q_end   = (qcnt == 10'(CLK_DIV - 1));
        bit_end = q_end && (quarter == 2'd3);
        pre_mid = (quarter == 2'd0) && (qcnt == 10'(CLK_DIV - 2));
        nq      = q_end ? quarter + 2'd1 : quarter;
        timed   = (state == START) || (state == BIT) || (state == ACK) ||
                  (state == STOP)  || (state == GAP);
    end

    assign read = 1'b0;

    // Sequencer FSM, quarter timer and all registered bus/control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            qcnt                   <= '0;
            quarter                <= '0;
            bit_cnt                <= '0;
            byte_cnt               <= '0;
            mlp_d                  <= 1'b0;
            nack                   <= 1'b0;
            scl                    <= 1'b1;
            sda_oe                 <= 1'b0;
            fsm_enable             <= 1'b0;
            middle_low_cycle_pulse <= 1'b0;
            reg_num                <= '0;
            use_mem_data           <= 1'b0;
            byte_select            <= 1'b0;
            load                   <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            ack_error              <= 1'b0;
        end else begin
            if (timed) begin
                qcnt    <= q_end ? '0 : qcnt + 10'd1;
                quarter <= nq;
            end
            mlp_d                  <= middle_low_cycle_pulse;
            load                   <= 1'b0;
            middle_low_cycle_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    scl    <= 1'b1;
                    sda_oe <= 1'b0;
                    busy   <= 1'b0;
                    if (start) begin
                        state        <= START;
                        reg_num      <= '0;
                        byte_cnt     <= '0;
                        ack_error    <= 1'b0;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        qcnt         <= '0;
                        quarter      <= '0;
                        use_mem_data <= 1'b0;
                        byte_select  <= 1'b0;
                    end
                end
                START: begin
                    // SDA falls in the second half while SCL stays high
                    scl    <= 1'b1;
                    sda_oe <= nq[1];
                    if (bit_end) begin
                        state   <= BIT;
                        bit_cnt <= 3'd7;
                        scl     <= 1'b0;
                        sda_oe  <= 1'b1;
                    end
                end
                BIT: begin
                    scl                    <= nq[1];
                    middle_low_cycle_pulse <= pre_mid;
                    load                   <= pre_mid && (bit_cnt == 3'd7);
                    // one cycle after the strobe the shift register already shows the new MSB
                    if (mlp_d)
                        sda_oe <= ~shift_reg_out;
                    if (bit_end) begin
                        if (bit_cnt == 3'd0) begin
                            state      <= ACK;
                            fsm_enable <= 1'b0;
                        end else begin
                            bit_cnt    <= bit_cnt - 3'd1;
                            fsm_enable <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    scl                    <= nq[1];
                    middle_low_cycle_pulse <= pre_mid;
                    if (middle_low_cycle_pulse)
                        sda_oe <= 1'b0;
                    if ((quarter == 2'd2) && q_end)
                        nack <= sda_in;
                    if (bit_end) begin
                        if (nack) begin
                            ack_error <= 1'b1;
                            state     <= STOP;
                            sda_oe    <= 1'b1;
                        end else if (byte_cnt == 2'd2) begin
                            state  <= STOP;
                            sda_oe <= 1'b1;
                        end else begin
                            state        <= BIT;
                            bit_cnt      <= 3'd7;
                            byte_cnt     <= byte_cnt + 2'd1;
                            use_mem_data <= 1'b1;
                            byte_select  <= (byte_cnt == 2'd0);
                        end
                    end
                end
                STOP: begin
                    // SDA rises in the last quarter while SCL is high
                    scl    <= nq[1];
                    sda_oe <= (nq != 2'd3);
                    if (bit_end) begin
                        scl          <= 1'b1;
                        sda_oe       <= 1'b0;
                        byte_cnt     <= '0;
                        use_mem_data <= 1'b0;
                        byte_select  <= 1'b0;
                        if (ack_error || (reg_num == 4'(NUM_REGS - 1))) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state   <= GAP;
                            reg_num <= reg_num + 4'd1;
                        end
                    end
                end
                GAP: begin
                    scl    <= 1'b1;
                    sda_oe <= 1'b0;
                    if (bit_end)
                        state <= START;
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_config_seq.sv
// tb/tb_i2c_config_seq.sv - scoreboard bench for i2c_config_seq with bus decoder and shift register model
module tb_i2c_config_seq;

    localparam int CLK_DIV  = 4;
    localparam int NUM_REGS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sda_in;
    logic       shift_reg_out;
    logic       scl, sda_oe, fsm_enable, middle_low_cycle_pulse;
    logic [3:0] reg_num;
    logic       read, use_mem_data, byte_select, load, busy, done, ack_error;

    i2c_config_seq #(.CLK_DIV(CLK_DIV), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sda_in(sda_in),
        .shift_reg_out(shift_reg_out), .scl(scl), .sda_oe(sda_oe),
        .fsm_enable(fsm_enable), .middle_low_cycle_pulse(middle_low_cycle_pulse),
        .reg_num(reg_num), .read(read), .use_mem_data(use_mem_data),
        .byte_select(byte_select), .load(load), .busy(busy), .done(done),
        .ack_error(ack_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // expected bytes on the bus, in order
    logic [7:0] exp_q[$];

    // downstream memory (1-cycle read latency) and byte shift register
    logic [15:0] mem_q = '0;
    logic [7:0]  sr = '0;
    always @(posedge clk) begin
        mem_q <= (reg_num == 4'd0) ? 16'h125A : 16'hA5C3;
        if (load)
            sr <= use_mem_data ? (byte_select ? mem_q[15:8] : mem_q[7:0]) : {7'h3C, read};
        else if (fsm_enable && middle_low_cycle_pulse)
            sr <= {sr[6:0], 1'b0};
    end
    assign shift_reg_out = sr[7];

    // bus decoder / monitor state
    int         bitcnt = 0;
    int         byte_idx = 0;
    logic       ack_seen = 1'b0;
    logic [7:0] shreg = '0;
    logic       prev_scl = 1'b1;
    logic       prev_oe = 1'b0;
    logic [3:0] prev_reg = '0;
    int         reg_age = 0;
    int         start_ev = 0, stop_ev = 0, loads = 0, shifts = 0;
    int         byte_loads = 0, byte_shifts = 0;
    logic       nack_mode = 1'b0;

    // slave answers NACK on the register-address byte when asked to
    assign sda_in = (nack_mode && byte_idx == 1 && bitcnt == 8) ? 1'b1 : 1'b0;

    // monitor: decode bus, pop scoreboard on each completed byte
    always @(negedge clk) begin
        if (!rst_n) begin
            bitcnt = 0; byte_idx = 0; ack_seen = 1'b0;
            byte_loads = 0; byte_shifts = 0;
            prev_scl = 1'b1; prev_oe = 1'b0; prev_reg = '0; reg_age = 0;
        end else begin
            if (prev_scl && scl && sda_oe != prev_oe) begin
                if (sda_oe) begin
                    start_ev++; bitcnt = 0; ack_seen = 1'b0; byte_idx = 0;
                    byte_loads = 0; byte_shifts = 0;
                end else begin
                    stop_ev++;
                end
            end
            if (!prev_scl && scl) begin
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], ~sda_oe};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        if (exp_q.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL byte_unexpected: got %02h expected none", shreg);
                        end else begin
                            check("byte_value", int'(shreg), int'(exp_q.pop_front()));
                        end
                        check("loads_per_byte", byte_loads, 1);
                        check("shifts_per_byte", byte_shifts, 7);
                        byte_loads = 0; byte_shifts = 0;
                    end
                end else begin
                    ack_seen = 1'b1;
                end
            end
            if (prev_scl && !scl && ack_seen) begin
                bitcnt = 0; ack_seen = 1'b0; byte_idx++;
            end
            if (reg_num != prev_reg) reg_age = 0; else reg_age++;
            if (load) begin
                loads++; byte_loads++;
                check("load_on_mid_pulse", int'(middle_low_cycle_pulse), 1);
                if (use_mem_data) check("reg_num_setup", int'(reg_age >= 2), 1);
            end
            if (fsm_enable && middle_low_cycle_pulse) begin
                shifts++; byte_shifts++;
            end
            prev_scl = scl; prev_oe = sda_oe; prev_reg = reg_num;
        end
    end

    task automatic push_entry(input int e);
        exp_q.push_back(8'h78);
        exp_q.push_back(e == 0 ? 8'h12 : 8'hA5);
        exp_q.push_back(e == 0 ? 8'h5A : 8'hC3);
    endtask

    // pulse start, optionally poke start mid-run, wait for done, then poke on the done cycle
    task automatic run_seq(input int poke, input int exp_lat);
        int n;
        int s0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        check("busy_after_start", int'(busy), 1);
        check("done_cleared", int'(done), 0);
        check("ack_error_cleared", int'(ack_error), 0);
        while (done !== 1'b1 && n < 3000) begin
            if (n == poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        check("done_latency", n, exp_lat);
        s0 = start_ev;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("done_cycle_start_busy", int'(busy), 0);
        check("done_cycle_start_done", int'(done), 1);
        check("done_cycle_start_no_bus", start_ev - s0, 0);
    endtask

    initial begin
        int s0, p0, l0, h0, n;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl", int'(scl), 1);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ack_error", int'(ack_error), 0);
        check("rst_reg_num", int'(reg_num), 0);
        check("rst_load", int'(load), 0);
        check("rst_fsm_enable", int'(fsm_enable), 0);
        check("rst_mid_pulse", int'(middle_low_cycle_pulse), 0);
        check("rst_use_mem", int'(use_mem_data), 0);
        check("read_const", int'(read), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // full two-entry run with a start poke while busy
        push_entry(0); push_entry(1);
        s0 = start_ev; p0 = stop_ev; l0 = loads; h0 = shifts;
        run_seq(300, 944);
        check("run1_reg_num", int'(reg_num), 1);
        check("run1_ack_error", int'(ack_error), 0);
        check("run1_queue_empty", exp_q.size(), 0);
        check("run1_start_cond", start_ev - s0, 2);
        check("run1_stop_cond", stop_ev - p0, 2);
        check("run1_loads", loads - l0, 6);
        check("run1_shifts", shifts - h0, 42);

        // NACK on register-address byte of entry 0
        nack_mode = 1'b1;
        exp_q.push_back(8'h78); exp_q.push_back(8'h12);
        s0 = start_ev; p0 = stop_ev; l0 = loads;
        run_seq(-1, 320);
        nack_mode = 1'b0;
        check("nack_ack_error", int'(ack_error), 1);
        check("nack_done", int'(done), 1);
        check("nack_reg_num", int'(reg_num), 0);
        check("nack_queue_empty", exp_q.size(), 0);
        check("nack_loads", loads - l0, 2);
        check("nack_start_cond", start_ev - s0, 1);
        check("nack_stop_cond", stop_ev - p0, 1);

        // ack_error must clear on the next accepted start
        push_entry(0); push_entry(1);
        run_seq(-1, 944);
        check("run2_queue_empty", exp_q.size(), 0);
        check("run2_ack_error", int'(ack_error), 0);

        // reset during BIT of entry 1
        push_entry(0);
        p0 = stop_ev;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(reg_num == 4'd1 && fsm_enable && middle_low_cycle_pulse) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reached_entry1", int'(n < 3000), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_scl", int'(scl), 1);
        check("midrst_sda_oe", int'(sda_oe), 0);
        check("midrst_reg_num", int'(reg_num), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_fsm_enable", int'(fsm_enable), 0);
        check("midrst_one_stop", stop_ev - p0, 1);
        check("midrst_queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("midrst_no_stop_after", stop_ev - p0, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // fresh start after reset begins at entry 0
        push_entry(0); push_entry(1);
        s0 = start_ev; p0 = stop_ev;
        run_seq(-1, 944);
        check("run3_queue_empty", exp_q.size(), 0);
        check("run3_reg_num", int'(reg_num), 1);
        check("run3_start_cond", start_ev - s0, 2);
        check("run3_stop_cond", stop_ev - p0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
